// File: rtl/if_fetch_stage_if.sv
// Bundle of the fetch stage's control inputs, instruction-memory bus and IF/ID outputs.
// The DUT connects through the master modport; the environment uses slave.
interface if_fetch_stage_if #(
  parameter int CNT_W = 32
);
  logic [31:0]      start_pc;
  logic             stall;
  logic             flush;
  logic             redirect_vld;
  logic [31:0]      redirect_pc;
  logic [31:0]      imem_addr;
  logic [31:0]      imem_rdata;
  logic [31:0]      pc;
  logic [31:0]      ifid_instr;
  logic [31:0]      ifid_pc4;
  logic             ifid_valid;
  logic             misalign_err;
  logic [CNT_W-1:0] fetch_count;

  modport master (
    input  start_pc, stall, flush, redirect_vld, redirect_pc, imem_rdata,
    output imem_addr, pc, ifid_instr, ifid_pc4, ifid_valid, misalign_err, fetch_count
  );

  modport slave (
    output start_pc, stall, flush, redirect_vld, redirect_pc, imem_rdata,
    input  imem_addr, pc, ifid_instr, ifid_pc4, ifid_valid, misalign_err, fetch_count
  );
endinterface

// File: rtl/if_fetch_stage.sv
// MIPS instruction-fetch stage: program counter, IF/ID register, stall/flush/redirect handling,
// a sticky misalignment flag and a count of instructions accepted into IF/ID.
module if_fetch_stage #(
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000,
  parameter int          CNT_W     = 32
) (
  input logic            clk_i,
  input logic            rst_i,
  if_fetch_stage_if.master bus
);
  logic [31:0]      pc_q, pc_d;
  logic [31:0]      instr_q, instr_d;
  logic [31:0]      pc4_q, pc4_d;
  logic             valid_q, valid_d;
  logic             mis_q, mis_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      pc_plus4;

  assign pc_plus4 = pc_q + 32'd4;

  always_comb begin
    pc_d    = pc_q;
    instr_d = instr_q;
    pc4_d   = pc4_q;
    valid_d = valid_q;
    mis_d   = mis_q;
    cnt_d   = cnt_q;
    if (bus.redirect_vld) begin
      // Redirect squashes IF/ID even when stalled; the wrong-path word is dropped.
      pc_d    = {bus.redirect_pc[31:2], 2'b00};
      instr_d = NOP_INSTR;
      pc4_d   = '0;
      valid_d = 1'b0;
      if (bus.redirect_pc[1:0] != 2'b00) mis_d = 1'b1;
    end else if (bus.stall) begin
      if (bus.flush) begin
        instr_d = NOP_INSTR;
        pc4_d   = '0;
        valid_d = 1'b0;
      end
    end else if (bus.flush) begin
      pc_d    = pc_plus4;
      instr_d = NOP_INSTR;
      pc4_d   = '0;
      valid_d = 1'b0;
    end else begin
      pc_d    = pc_plus4;
      instr_d = bus.imem_rdata;
      pc4_d   = pc_plus4;
      valid_d = 1'b1;
      cnt_d   = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pc_q    <= {bus.start_pc[31:2], 2'b00};
      instr_q <= NOP_INSTR;
      pc4_q   <= '0;
      valid_q <= 1'b0;
      mis_q   <= (bus.start_pc[1:0] != 2'b00);
      cnt_q   <= '0;
    end else begin
      pc_q    <= pc_d;
      instr_q <= instr_d;
      pc4_q   <= pc4_d;
      valid_q <= valid_d;
      mis_q   <= mis_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.imem_addr    = pc_q;
  assign bus.pc           = pc_q;
  assign bus.ifid_instr   = instr_q;
  assign bus.ifid_pc4     = pc4_q;
  assign bus.ifid_valid   = valid_q;
  assign bus.misalign_err = mis_q;
  assign bus.fetch_count  = cnt_q;
endmodule
